// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator: raster pixel stream in, zero-padded, strided 9-value windows out.
// Latency: one cycle from the advance that completes a window to out_valid.
// Backpressure: a held, unaccepted window stalls the scan, and in_ready stays low until the slot frees.
module conv_window_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 5,
    parameter int HEIGHT     = 5,
    parameter int PAD        = 1,
    parameter int STRIDE     = 1,
    parameter int COORD_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [9*DATA_WIDTH-1:0] win_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COORD_W-1:0]      out_row,
    output logic [COORD_W-1:0]      out_col,
    output logic                    busy,
    output logic                    frame_done
);
    localparam int PW    = WIDTH + 2 * PAD;
    localparam int PH    = HEIGHT + 2 * PAD;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] PW_M1 = CNT_W'(PW - 1);
    localparam logic [CNT_W-1:0] PH_M1 = CNT_W'(PH - 1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       row_q, row_d, col_q, col_d;
    logic [DATA_WIDTH-1:0]  lb0_q [PW];
    logic [DATA_WIDTH-1:0]  lb0_d [PW];
    logic [DATA_WIDTH-1:0]  lb1_q [PW];
    logic [DATA_WIDTH-1:0]  lb1_d [PW];
    logic [DATA_WIDTH-1:0]  win_q [9];
    logic [DATA_WIDTH-1:0]  win_d [9];
    logic [9*DATA_WIDTH-1:0] owin_q, owin_d;
    logic                   ovld_q, ovld_d;
    logic [COORD_W-1:0]     orow_q, orow_d, ocol_q, ocol_d;

    logic                   is_pad, slot_free, advance, last_pos, win_done;
    logic [DATA_WIDTH-1:0]  sample;
    logic [CNT_W-1:0]       row_m2, col_m2;

    // Decode the current scan position and whether the scan can step this cycle
    always_comb begin
        is_pad    = (PAD == 1) && (row_q == '0 || row_q == PH_M1 || col_q == '0 || col_q == PW_M1);
        slot_free = !ovld_q || out_ready;
        advance   = (state_q == S_RUN) && slot_free && (is_pad || in_valid);
        sample    = is_pad ? '0 : in_data;
        last_pos  = (row_q == PH_M1) && (col_q == PW_M1);
        row_m2    = row_q - TWO;
        col_m2    = col_q - TWO;
        // Row >= 2 gating also keeps stale line-buffer data from a previous frame off the output
        win_done  = (row_q >= TWO) && (col_q >= TWO) &&
                    ((STRIDE == 1) || (!row_m2[0] && !col_m2[0]));
    end

    // Next-state logic for the frame FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (advance && last_pos) state_d = S_FLUSH;
            S_FLUSH: if (slot_free) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM-derived outputs; frame_done marks the cycle the last window leaves (or FLUSH with nothing held)
    always_comb begin
        busy       = (state_q != S_IDLE);
        in_ready   = (state_q == S_RUN) && !is_pad && slot_free;
        frame_done = (state_q == S_FLUSH) && slot_free;
    end

    // Scan counters, line buffers and window column shift
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        lb0_d = lb0_q;
        lb1_d = lb1_q;
        win_d = win_q;
        if (state_q == S_IDLE && start) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_q == PW_M1) begin
                col_d = '0;
                row_d = row_q + ONE;
            end else begin
                col_d = col_q + ONE;
            end
            lb0_d[0] = sample;
            lb1_d[0] = lb0_q[PW-1];
            for (int i = 1; i < PW; i++) begin
                lb0_d[i] = lb0_q[i-1];
                lb1_d[i] = lb1_q[i-1];
            end
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]   = win_q[3*r+1];
                win_d[3*r+1] = win_q[3*r+2];
            end
            // New right-hand column: two rows up, one row up, current sample
            win_d[2] = lb1_q[PW-1];
            win_d[5] = lb0_q[PW-1];
            win_d[8] = sample;
        end
    end

    // Output slot: load a completed window, otherwise hold until accepted
    always_comb begin
        ovld_d = ovld_q && !out_ready;
        owin_d = owin_q;
        orow_d = orow_q;
        ocol_d = ocol_q;
        if (advance && win_done) begin
            ovld_d = 1'b1;
            for (int i = 0; i < 9; i++) begin
                owin_d[i*DATA_WIDTH +: DATA_WIDTH] = win_d[i];
            end
            orow_d = COORD_W'((STRIDE == 2) ? (row_m2 >> 1) : row_m2);
            ocol_d = COORD_W'((STRIDE == 2) ? (col_m2 >> 1) : col_m2);
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            ovld_q  <= 1'b0;
            owin_q  <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ovld_q  <= ovld_d;
            owin_q  <= owin_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
        end
    end

    // Pixel storage needs no reset: nothing stale can be emitted
    always_ff @(posedge clk) begin
        lb0_q <= lb0_d;
        lb1_q <= lb1_d;
        win_q <= win_d;
    end

    assign out_valid = ovld_q;
    assign win_data  = owin_q;
    assign out_row   = orow_q;
    assign out_col   = ocol_q;
endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, in_valid, out_ready;
    logic [DW-1:0] in_data;
    int            sel;

    logic          start_v   [3];
    logic          in_ready_v[3];
    logic          out_vld_v [3];
    logic          busy_v    [3];
    logic          done_v    [3];
    logic [9*DW-1:0] win_v   [3];
    logic [7:0]    row_v     [3];
    logic [7:0]    col_v     [3];

    logic          o_in_ready, o_valid, o_busy, o_done;
    logic [9*DW-1:0] o_win;
    logic [7:0]    o_row, o_col;

    always_comb begin
        for (int k = 0; k < 3; k++) start_v[k] = start && (sel == k);
        o_in_ready = in_ready_v[sel];
        o_valid    = out_vld_v[sel];
        o_busy     = busy_v[sel];
        o_done     = done_v[sel];
        o_win      = win_v[sel];
        o_row      = row_v[sel];
        o_col      = col_v[sel];
    end

    conv_window_gen #(.DATA_WIDTH(DW), .WIDTH(5), .HEIGHT(5), .PAD(1), .STRIDE(1), .COORD_W(8)) u_p1s1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_v[0]), .win_data(win_v[0]), .out_valid(out_vld_v[0]), .out_ready(out_ready),
        .out_row(row_v[0]), .out_col(col_v[0]), .busy(busy_v[0]), .frame_done(done_v[0]));
    conv_window_gen #(.DATA_WIDTH(DW), .WIDTH(5), .HEIGHT(5), .PAD(0), .STRIDE(1), .COORD_W(8)) u_p0s1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_v[1]), .win_data(win_v[1]), .out_valid(out_vld_v[1]), .out_ready(out_ready),
        .out_row(row_v[1]), .out_col(col_v[1]), .busy(busy_v[1]), .frame_done(done_v[1]));
    conv_window_gen #(.DATA_WIDTH(DW), .WIDTH(5), .HEIGHT(5), .PAD(1), .STRIDE(2), .COORD_W(8)) u_p1s2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_v[2]), .win_data(win_v[2]), .out_valid(out_vld_v[2]), .out_ready(out_ready),
        .out_row(row_v[2]), .out_col(col_v[2]), .busy(busy_v[2]), .frame_done(done_v[2]));

    int n_checks = 0;
    int n_pass   = 0;

    logic [9*DW-1:0] wq_dat[$];
    int              wq_row[$];
    int              wq_col[$];
    int n_consumed, n_inrdy, first_inrdy, n_done, n_stall;

    task automatic check(input string tag, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    function automatic logic [9*DW-1:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        logic [9*DW-1:0] v;
        v = {DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
        return v;
    endfunction

    // Reference window for output (orow, ocol) of a WxH image of pixels 1..W*H
    function automatic logic [9*DW-1:0] exp_win(input int w, h, p, s, orow, ocol);
        logic [9*DW-1:0] v;
        int r, c, val;
        v = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                r = orow * s + dr;
                c = ocol * s + dc;
                if (p == 1 && (r == 0 || r == h + 1 || c == 0 || c == w + 1)) val = 0;
                else val = (r - p) * w + (c - p) + 1;
                v[(dr*3+dc)*DW +: DW] = DW'(val);
            end
        end
        return v;
    endfunction

    task automatic check_seq(input string tag, input int w, h, p, s);
        int ow, oh, n;
        ow = (w + 2*p - 3) / s + 1;
        oh = (h + 2*p - 3) / s + 1;
        check({tag, "_count"}, (9*DW)'(wq_dat.size()), (9*DW)'(ow * oh));
        n = (wq_dat.size() < ow * oh) ? wq_dat.size() : ow * oh;
        for (int i = 0; i < n; i++) begin
            check({tag, "_win"}, wq_dat[i], exp_win(w, h, p, s, i / ow, i % ow));
            check({tag, "_row"}, (9*DW)'(wq_row[i]), (9*DW)'(i / ow));
            check({tag, "_col"}, (9*DW)'(wq_col[i]), (9*DW)'(i % ow));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, (9*DW)'(o_in_ready), '0);
        check({tag, "_out_valid"}, (9*DW)'(o_valid), '0);
        check({tag, "_busy"}, (9*DW)'(o_busy), '0);
        check({tag, "_frame_done"}, (9*DW)'(o_done), '0);
        check({tag, "_win_data"}, o_win, '0);
        check({tag, "_out_row"}, (9*DW)'(o_row), '0);
        check({tag, "_out_col"}, (9*DW)'(o_col), '0);
    endtask

    // Runs one frame of pixels 1..25; entered and left just after a rising edge.
    // abort_after > 0 returns once that many pixels have been consumed.
    task automatic run_frame(input bit gaps, input int stall_at, input int abort_after);
        int pix, cyc;
        bit done, prev_stall, consumed;
        logic [9*DW-1:0] pw;
        logic [7:0] pr, pc;
        wq_dat.delete(); wq_row.delete(); wq_col.delete();
        n_consumed = 0; n_inrdy = 0; first_inrdy = -1; n_done = 0; n_stall = 0;
        pix = 1; done = 0; prev_stall = 0; cyc = 0;
        pw = '0; pr = '0; pc = '0;
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && cyc < 500) begin
            out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
            in_valid  = (pix <= 25) && (!gaps || $urandom_range(0, 2) != 0);
            in_data   = DW'(pix);
            @(negedge clk);
            if (prev_stall) begin
                check("stall_valid", (9*DW)'(o_valid), 1);
                check("stall_win", o_win, pw);
                check("stall_row", (9*DW)'(o_row), (9*DW)'(pr));
                check("stall_col", (9*DW)'(o_col), (9*DW)'(pc));
            end
            if (o_valid && !out_ready) begin
                check("stall_in_ready", (9*DW)'(o_in_ready), '0);
                n_stall++;
            end
            prev_stall = o_valid && !out_ready;
            pw = o_win; pr = o_row; pc = o_col;
            if (o_in_ready) begin
                n_inrdy++;
                if (first_inrdy < 0) first_inrdy = cyc;
            end
            consumed = in_valid && o_in_ready;
            if (o_valid && out_ready) begin
                wq_dat.push_back(o_win);
                wq_row.push_back(int'(o_row));
                wq_col.push_back(int'(o_col));
            end
            if (o_done) begin
                n_done++;
                done = 1;
            end
            @(posedge clk); #1;
            if (consumed) begin
                pix++;
                n_consumed++;
            end
            cyc++;
            if (abort_after > 0 && n_consumed >= abort_after) return;
        end
        in_valid = 1'b0;
        if (!done) check("frame_timeout", '0, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Padded, stride 1, free-flowing consumer
        sel = 0;
        run_frame(0, -1, 0);
        check_seq("p1s1", 5, 5, 1, 1);
        check("p1s1_first", wq_dat[0], pack9(0, 0, 0, 0, 1, 2, 0, 6, 7));
        check("p1s1_last", wq_dat[wq_dat.size()-1], pack9(19, 20, 0, 24, 25, 0, 0, 0, 0));
        check("p1s1_pixels", (9*DW)'(n_consumed), 25);
        check("p1s1_in_ready_cycles", (9*DW)'(n_inrdy), 25);
        check("p1s1_first_in_ready", (9*DW)'(first_inrdy), 8);
        @(negedge clk);
        check("p1s1_done_single", (9*DW)'(o_done), '0);
        check("p1s1_idle", (9*DW)'(o_busy), '0);
        @(posedge clk); #1;

        // No padding
        sel = 1;
        run_frame(0, -1, 0);
        check_seq("p0s1", 5, 5, 0, 1);
        check("p0s1_first", wq_dat[0], pack9(1, 2, 3, 6, 7, 8, 11, 12, 13));
        check("p0s1_last", wq_dat[wq_dat.size()-1], pack9(13, 14, 15, 18, 19, 20, 23, 24, 25));
        check("p0s1_last_row", (9*DW)'(wq_row[wq_row.size()-1]), 2);
        check("p0s1_pixels", (9*DW)'(n_consumed), 25);
        @(posedge clk); #1;

        // Padded, stride 2
        sel = 2;
        run_frame(0, -1, 0);
        check_seq("p1s2", 5, 5, 1, 2);
        check("p1s2_mid", wq_dat[4], pack9(7, 8, 9, 12, 13, 14, 17, 18, 19));
        check("p1s2_mid_row", (9*DW)'(wq_row[4]), 1);
        check("p1s2_mid_col", (9*DW)'(wq_col[4]), 1);
        @(posedge clk); #1;

        // Input gaps plus a 3-cycle consumer stall
        sel = 0;
        run_frame(1, 30, 0);
        check_seq("stall", 5, 5, 1, 1);
        check("stall_pixels", (9*DW)'(n_consumed), 25);
        check("stall_seen", (9*DW)'(n_stall != 0), 1);
        @(posedge clk); #1;

        // Reset mid-frame, then a fresh frame
        run_frame(0, -1, 10);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        run_frame(0, -1, 0);
        check_seq("after_rst", 5, 5, 1, 1);
        check("after_rst_pixels", (9*DW)'(n_consumed), 25);

        // Back-to-back: start in the cycle right after frame_done
        run_frame(0, -1, 0);
        check("b2b_first", wq_dat[0], pack9(0, 0, 0, 0, 1, 2, 0, 6, 7));
        check_seq("b2b", 5, 5, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
